// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard unit. Produces operand forwarding selects,
// the load-use / long-latency stall, a per-register scoreboard of in-flight
// mul/div writes and a stall watchdog with a sticky timeout flag.
module hazard_scoreboard #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_we,
  input  logic                  ex_is_load,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_we,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_we,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_rd,
  input  logic                  lu_done,
  input  logic [REG_ADDR_W-1:0] lu_done_rd,
  output logic                  stall,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel,
  output logic [CNT_W-1:0]      busy_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  stall_timeout
);

  localparam int                NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [CNT_W-1:0]  LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Scoreboard and watchdog state
  logic [NUM_REGS-1:0] r_sb;
  logic [CNT_W-1:0]    r_busy_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                r_timeout;

  // Per-source combinational results (index 0 = rs1, 1 = rs2)
  logic [1:0][REG_ADDR_W-1:0] w_src;
  logic [1:0]                 w_used;
  logic [1:0][1:0]            w_sel;
  logic [1:0]                 w_hazard;

  logic [NUM_REGS-1:0] w_sb_next;
  logic [CNT_W-1:0]    w_pop;
  logic                w_stall;

  assign w_src[0]  = id_rs1;
  assign w_src[1]  = id_rs2;
  assign w_used[0] = id_rs1_used;
  assign w_used[1] = id_rs2_used;

  genvar gi;

  // Producer matching, forwarding priority and hazard detection for each source
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic w_live;
      logic w_ex_hit;
      logic w_mem_hit;
      logic w_wb_hit;

      // x0 and unused sources never match any producer
      assign w_live    = w_used[gi] && (w_src[gi] != '0);
      assign w_ex_hit  = w_live && ex_valid  && ex_we  && (ex_rd  == w_src[gi]);
      assign w_mem_hit = w_live && mem_valid && mem_we && (mem_rd == w_src[gi]);
      assign w_wb_hit  = w_live && wb_valid  && wb_we  && (wb_rd  == w_src[gi]);

      // Youngest producer wins; a load in EXE has no data yet, so fall through to older stages
      always_comb begin
        w_sel[gi] = 2'd0;
        if (w_ex_hit && !ex_is_load) begin
          w_sel[gi] = 2'd1;
        end else if (w_mem_hit) begin
          w_sel[gi] = 2'd2;
        end else if (w_wb_hit) begin
          w_sel[gi] = 2'd3;
        end
      end

      assign w_hazard[gi] = (w_ex_hit && ex_is_load) || (w_live && r_sb[w_src[gi]]);
    end
  endgenerate

  // Next scoreboard: set wins over clear on the same register, x0 is never tracked
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign w_sb_next[gi] = 1'b0;
      end else begin : g_bit
        logic w_set;
        logic w_clr;
        assign w_set         = lu_issue && (lu_issue_rd == REG_ADDR_W'(gi));
        assign w_clr         = lu_done  && (lu_done_rd  == REG_ADDR_W'(gi));
        assign w_sb_next[gi] = w_set || (r_sb[gi] && !w_clr);
      end
    end
  endgenerate

  // Population count of the next scoreboard, registered into busy_cnt
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pop = w_pop + CNT_W'(w_sb_next[i]);
    end
  end

  // Outputs are forced quiet while reset is asserted
  assign w_stall     = reset_n && id_valid && (|w_hazard);
  assign stall       = w_stall;
  assign fwd_rs1_sel = reset_n ? w_sel[0] : 2'd0;
  assign fwd_rs2_sel = reset_n ? w_sel[1] : 2'd0;

  // Scoreboard register and its registered occupancy count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sb       <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_sb       <= w_sb_next;
      r_busy_cnt <= w_pop;
    end
  end

  // Watchdog: count consecutive stall cycles (saturating) and latch the timeout
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_stall) begin
        if (r_stall_cnt != CNT_MAX) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
        if (r_stall_cnt == LIMIT_M1) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign busy_cnt      = r_busy_cnt;
  assign stall_cnt     = r_stall_cnt;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural model of the hazard rules.
module tb_hazard_scoreboard;

  localparam int AW    = 5;
  localparam int NREG  = 32;
  localparam int LIMIT = 64;
  localparam int CW    = 7;
  localparam int CMAX  = 127;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2;
  logic          id_rs1_used, id_rs2_used;
  logic          ex_valid, ex_we, ex_is_load;
  logic [AW-1:0] ex_rd;
  logic          mem_valid, mem_we;
  logic [AW-1:0] mem_rd;
  logic          wb_valid, wb_we;
  logic [AW-1:0] wb_rd;
  logic          lu_issue, lu_done;
  logic [AW-1:0] lu_issue_rd, lu_done_rd;
  logic          stall;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
  logic [CW-1:0] busy_cnt, stall_cnt;
  logic          stall_timeout;

  int checks = 0;
  int errors = 0;

  // Reference state: which registers have a long-latency write pending
  bit m_busy [NREG];
  int m_busy_cnt;
  int m_stall_cnt;
  bit m_timeout;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(AW), .STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_we(mem_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_done(lu_done), .lu_done_rd(lu_done_rd),
    .stall(stall), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .busy_cnt(busy_cnt), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Forwarding source for one operand: youngest real producer of the value
  function automatic logic [1:0] m_fwd(input logic [AW-1:0] s, input logic u);
    if (!reset_n || !u || s == 0) return 2'd0;
    if (ex_valid && ex_we && !ex_is_load && ex_rd == s) return 2'd1;
    if (mem_valid && mem_we && mem_rd == s) return 2'd2;
    if (wb_valid && wb_we && wb_rd == s) return 2'd3;
    return 2'd0;
  endfunction

  // Operand not yet available: pending load in EXE or pending long-latency write
  function automatic bit m_blocked(input logic [AW-1:0] s, input logic u);
    if (!u || s == 0) return 1'b0;
    if (ex_valid && ex_we && ex_is_load && ex_rd == s) return 1'b1;
    return m_busy[s];
  endfunction

  function automatic bit m_stall();
    return reset_n && id_valid && (m_blocked(id_rs1, id_rs1_used) || m_blocked(id_rs2, id_rs2_used));
  endfunction

  task automatic settle();
    #1;
    chk("stall", stall, m_stall());
    chk("fwd1", fwd_rs1_sel, m_fwd(id_rs1, id_rs1_used));
    chk("fwd2", fwd_rs2_sel, m_fwd(id_rs2, id_rs2_used));
    chk("busy_cnt", busy_cnt, m_busy_cnt);
    chk("stall_cnt", stall_cnt, m_stall_cnt);
    chk("timeout", stall_timeout, m_timeout);
  endtask

  task automatic tick();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (!reset_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_stall_cnt = 0;
      m_timeout   = 1'b0;
    end else begin
      if (lu_done) m_busy[lu_done_rd] = 1'b0;
      if (lu_issue && lu_issue_rd != 0) m_busy[lu_issue_rd] = 1'b1;
      if (st) begin
        if (m_stall_cnt == LIMIT - 1) m_timeout = 1'b1;
        m_stall_cnt = (m_stall_cnt < CMAX) ? m_stall_cnt + 1 : CMAX;
      end else begin
        m_stall_cnt = 0;
      end
    end
    m_busy_cnt = 0;
    foreach (m_busy[i]) m_busy_cnt += int'(m_busy[i]);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    ex_valid = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0;
    mem_valid = 0; mem_rd = 0; mem_we = 0;
    wb_valid = 0; wb_rd = 0; wb_we = 0;
    lu_issue = 0; lu_issue_rd = 0; lu_done = 0; lu_done_rd = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_busy_cnt = 0; m_stall_cnt = 0; m_timeout = 0;
    idle_inputs();
    do_reset();
    chk("reset_busy", busy_cnt, 0);
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_to", stall_timeout, 0);

    // 1. single producers in EXE, MEM, WB
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    ex_valid = 1; ex_we = 1; ex_rd = 5;
    settle(); chk("t1_ex_sel", fwd_rs1_sel, 1); chk("t1_ex_stall", stall, 0); tick();
    ex_valid = 0; mem_valid = 1; mem_we = 1; mem_rd = 5;
    settle(); chk("t1_mem_sel", fwd_rs1_sel, 2); tick();
    mem_valid = 0; wb_valid = 1; wb_we = 1; wb_rd = 5;
    settle(); chk("t1_wb_sel", fwd_rs1_sel, 3); tick();

    // 2. youngest wins; x0 never forwards
    idle_inputs();
    id_valid = 1; id_rs2 = 5; id_rs2_used = 1;
    ex_valid = 1; ex_we = 1; ex_rd = 5;
    mem_valid = 1; mem_we = 1; mem_rd = 5;
    wb_valid = 1; wb_we = 1; wb_rd = 5;
    settle(); chk("t2_young", fwd_rs2_sel, 1); tick();
    ex_rd = 0; mem_rd = 0; wb_rd = 0; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0;
    settle(); chk("t2_x0_sel", fwd_rs1_sel, 0); chk("t2_x0_stall", stall, 0); tick();

    // 3. load-use: stall one cycle, then forward from MEM
    idle_inputs();
    id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
    ex_valid = 1; ex_we = 1; ex_rd = 7; ex_is_load = 1;
    settle(); chk("t3_lu_stall", stall, 1); tick();
    ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_we = 1; mem_rd = 7;
    settle(); chk("t3_mem_stall", stall, 0); chk("t3_mem_sel", fwd_rs1_sel, 2); tick();

    // 4. scoreboard set / clear / same-cycle set+clear
    idle_inputs();
    id_valid = 1; id_rs2 = 9; id_rs2_used = 1;
    lu_issue = 1; lu_issue_rd = 9;
    settle(); chk("t4_pre", stall, 0); tick();
    lu_issue = 0;
    settle(); chk("t4_stall", stall, 1); chk("t4_busy", busy_cnt, 1); tick();
    lu_done = 1; lu_done_rd = 9;
    settle(); chk("t4_done_cyc", stall, 1); tick();
    lu_done = 0;
    settle(); chk("t4_clear", stall, 0); chk("t4_busy0", busy_cnt, 0); tick();
    lu_issue = 1; lu_issue_rd = 9; step();
    lu_done = 1; lu_done_rd = 9; step();
    lu_issue = 0; lu_done = 0;
    settle(); chk("t4_setwins", stall, 1); chk("t4_setwins_cnt", busy_cnt, 1); tick();
    lu_done = 1; step(); lu_done = 0;
    lu_issue = 1; lu_issue_rd = 0; step(); lu_issue = 0;
    settle(); chk("t4_x0_busy", busy_cnt, 0); tick();

    // 5. watchdog: reset by one idle cycle, timeout exactly at the limit, sticky
    idle_inputs();
    lu_issue = 1; lu_issue_rd = 3; step(); lu_issue = 0;
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
    for (int i = 0; i < 10; i++) step();
    chk("t5_cnt10", stall_cnt, 10);
    id_valid = 0; step();
    chk("t5_cnt_clr", stall_cnt, 0);
    id_valid = 1;
    for (int i = 0; i < LIMIT - 1; i++) step();
    chk("t5_before", stall_timeout, 0);
    chk("t5_cnt63", stall_cnt, LIMIT - 1);
    step();
    chk("t5_at", stall_timeout, 1);
    lu_done = 1; lu_done_rd = 3; step(); lu_done = 0;
    id_valid = 0; step(); step();
    chk("t5_sticky", stall_timeout, 1);
    chk("t5_cnt0", stall_cnt, 0);

    // 6. reset mid-stall with three pending writes
    idle_inputs();
    id_valid = 1; id_rs1 = 4; id_rs1_used = 1;
    lu_issue = 1; lu_issue_rd = 4; step();
    lu_issue_rd = 5; step();
    lu_issue_rd = 6; step();
    lu_issue = 0;
    settle(); chk("t6_busy3", busy_cnt, 3); chk("t6_stall", stall, 1); tick();
    reset_n = 0;
    settle(); chk("t6_rst_stall", stall, 0); tick();
    reset_n = 1;
    settle();
    chk("t6_busy0", busy_cnt, 0); chk("t6_cnt0", stall_cnt, 0);
    chk("t6_to0", stall_timeout, 0); chk("t6_nostall", stall, 0);
    tick();

    // Randomized traffic over a small register window to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      reset_n     = ($urandom_range(0, 299) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = AW'($urandom_range(0, 7));
      id_rs1_used = $urandom_range(0, 1);
      id_rs2      = AW'($urandom_range(0, 7));
      id_rs2_used = $urandom_range(0, 1);
      ex_valid    = $urandom_range(0, 1); ex_we = $urandom_range(0, 1);
      ex_rd       = AW'($urandom_range(0, 7)); ex_is_load = ($urandom_range(0, 3) == 0);
      mem_valid   = $urandom_range(0, 1); mem_we = $urandom_range(0, 1);
      mem_rd      = AW'($urandom_range(0, 7));
      wb_valid    = $urandom_range(0, 1); wb_we = $urandom_range(0, 1);
      wb_rd       = AW'($urandom_range(0, 7));
      lu_issue    = ($urandom_range(0, 3) == 0); lu_issue_rd = AW'($urandom_range(0, 7));
      lu_done     = ($urandom_range(0, 2) == 0); lu_done_rd  = AW'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
